// File: rtl/bike_rand_arbiter_if.sv
// Randomness handshake bundle between the shared source, the arbiter and the
// sampler bank.
//   REQ_RAND_REQU  : per-requester request, held while words are wanted
//   REQ_RAND_VALID : per-requester word strobe (one-hot or zero)
//   REQ_NEW_RAND   : shared word bus to the requesters
//   SRC_RAND_REQU  : request to the randomness source
//   SRC_RAND_VALID : source word strobe
//   SRC_NEW_RAND   : source word
// slave  = arbiter view, master = environment (source + samplers) view.
interface bike_rand_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]    REQ_RAND_REQU;
  logic [NUM_REQ-1:0]    REQ_RAND_VALID;
  logic [DATA_WIDTH-1:0] REQ_NEW_RAND;
  logic                  SRC_RAND_REQU;
  logic                  SRC_RAND_VALID;
  logic [DATA_WIDTH-1:0] SRC_NEW_RAND;

  modport slave (
    input  REQ_RAND_REQU,
    input  SRC_RAND_VALID,
    input  SRC_NEW_RAND,
    output REQ_RAND_VALID,
    output REQ_NEW_RAND,
    output SRC_RAND_REQU
  );

  modport master (
    output REQ_RAND_REQU,
    output SRC_RAND_VALID,
    output SRC_NEW_RAND,
    input  REQ_RAND_VALID,
    input  REQ_NEW_RAND,
    input  SRC_RAND_REQU
  );
endinterface

// File: rtl/bike_rand_arbiter.sv
// Round-robin arbiter sharing one randomness word stream between NUM_REQ
// uniform samplers. The owner's handshake is passed straight through to the
// source; an optional burst limit (MAX_BURST, 0 = unlimited) forces a
// handover when other samplers are waiting.
//   CLK          : system clock, rising edge
//   RESET        : asynchronous, active-high reset
//   rnd          : randomness handshake bundle (slave side)
//   GRANT_IDX    : current owner, qualify with GRANT_ACTIVE
//   GRANT_ACTIVE : high while a grant is held
//   BUSY         : high whenever the arbiter is not idle
module bike_rand_arbiter #(
  parameter  int unsigned NUM_REQ    = 3,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MAX_BURST  = 0,
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  bike_rand_arbiter_if.slave  rnd,
  output logic [IDX_W-1:0]    GRANT_IDX,
  output logic                GRANT_ACTIVE,
  output logic                BUSY
);

  localparam int unsigned      CNT_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic             BURST_ON  = (MAX_BURST != 0);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] burst_cnt;

  // Round-robin pick: rotate the request vector so rr_ptr lands on bit 0,
  // take the first set bit, then rotate the offset back.
  logic [NUM_REQ-1:0] req_rot;
  logic               pick_found;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;

  always_comb begin
    req_rot    = NUM_REQ'({rnd.REQ_RAND_REQU, rnd.REQ_RAND_REQU} >> rr_ptr);
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      end
    end
    if (pick_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (IDX_W + 1)'(NUM_REQ);
    end
    pick_idx = pick_sum[IDX_W-1:0];
  end

  // Owner-side handshake.
  logic [NUM_REQ-1:0] grant_oh;
  logic               owner_req;
  logic               others_req;
  logic               at_limit;
  logic               limit_hit;
  logic               in_grant;
  logic               src_requ;
  logic               deliver;
  logic [IDX_W-1:0]   next_ptr;

  always_comb begin
    grant_oh   = NUM_REQ'(1) << grant_idx;
    owner_req  = |(rnd.REQ_RAND_REQU & grant_oh);
    others_req = |(rnd.REQ_RAND_REQU & ~grant_oh);
    at_limit   = (burst_cnt == BURST_MAX);
    // The limit only bites while someone else is waiting; a lone owner
    // keeps streaming past MAX_BURST.
    limit_hit  = BURST_ON & at_limit & others_req;
    in_grant   = (state == S_GRANT);
    src_requ   = in_grant & owner_req & ~limit_hit;
    deliver    = src_requ & rnd.SRC_RAND_VALID;
    next_ptr   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  assign rnd.SRC_RAND_REQU  = src_requ;
  assign rnd.REQ_RAND_VALID = deliver ? grant_oh : '0;
  assign rnd.REQ_NEW_RAND   = deliver ? rnd.SRC_NEW_RAND : '0;

  assign GRANT_IDX    = grant_idx;
  assign GRANT_ACTIVE = in_grant;
  assign BUSY         = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (BURST_ON && deliver && !at_limit) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (!owner_req || limit_hit) begin
            rr_ptr <= next_ptr;
            state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bike_rand_arbiter.sv
module tb_bike_rand_arbiter;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  bike_rand_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32)) if0 ();
  bike_rand_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32)) if4 ();

  logic [1:0] gi0, gi4;
  logic       ga0, ga4, busy0, busy4;

  bike_rand_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .rnd(if0.slave),
    .GRANT_IDX(gi0), .GRANT_ACTIVE(ga0), .BUSY(busy0)
  );

  bike_rand_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .rnd(if4.slave),
    .GRANT_IDX(gi4), .GRANT_ACTIVE(ga4), .BUSY(busy4)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet_all();
    if0.REQ_RAND_REQU  = '0;
    if0.SRC_RAND_VALID = 1'b0;
    if0.SRC_NEW_RAND   = '0;
    if4.REQ_RAND_REQU  = '0;
    if4.SRC_RAND_VALID = 1'b0;
    if4.SRC_NEW_RAND   = '0;
  endtask

  task automatic do_reset();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    if0.REQ_RAND_REQU  = 3'b111;
    if0.SRC_RAND_VALID = 1'b1;
    if0.SRC_NEW_RAND   = 32'hDEADBEEF;
    if4.REQ_RAND_REQU  = 3'b111;
    if4.SRC_RAND_VALID = 1'b1;
    if4.SRC_NEW_RAND   = 32'hDEADBEEF;
    tick();
    tick();
    @(negedge CLK);
    n_total++; if (if0.SRC_RAND_REQU !== 1'b0) $display("FAIL reset_src_requ0: got %b want 0", if0.SRC_RAND_REQU); else n_pass++;
    n_total++; if (if0.REQ_RAND_VALID !== 3'b000) $display("FAIL reset_valid0: got %b want 000", if0.REQ_RAND_VALID); else n_pass++;
    n_total++; if (if0.REQ_NEW_RAND !== 32'h0) $display("FAIL reset_data0: got %h want 0", if0.REQ_NEW_RAND); else n_pass++;
    n_total++; if ({ga0, busy0, gi0} !== 4'b0000) $display("FAIL reset_status0: got %b want 0000", {ga0, busy0, gi0}); else n_pass++;
    n_total++; if (if4.SRC_RAND_REQU !== 1'b0) $display("FAIL reset_src_requ4: got %b want 0", if4.SRC_RAND_REQU); else n_pass++;
    n_total++; if ({ga4, busy4, gi4} !== 4'b0000) $display("FAIL reset_status4: got %b want 0000", {ga4, busy4, gi4}); else n_pass++;
    quiet_all();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] exp;
    tick();
    if0.REQ_RAND_REQU  = 3'b010;
    if0.SRC_RAND_VALID = 1'b1;
    if0.SRC_NEW_RAND   = 32'hDEADBEEF;
    @(negedge CLK);
    n_total++; if ({ga0, if0.SRC_RAND_REQU} !== 2'b00) $display("FAIL single_t0: got ga/src %b want 00", {ga0, if0.SRC_RAND_REQU}); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = 32'h1000_0000 + 32'(k);
      if0.SRC_NEW_RAND = exp;
      @(negedge CLK);
      n_total++; if (if0.REQ_RAND_VALID !== 3'b010) $display("FAIL single_valid[%0d]: got %b want 010", k, if0.REQ_RAND_VALID); else n_pass++;
      n_total++; if (if0.REQ_NEW_RAND !== exp) $display("FAIL single_data[%0d]: got %h want %h", k, if0.REQ_NEW_RAND, exp); else n_pass++;
      n_total++; if ({if0.SRC_RAND_REQU, gi0} !== 3'b101) $display("FAIL single_src_idx[%0d]: got %b want 101", k, {if0.SRC_RAND_REQU, gi0}); else n_pass++;
    end
    tick();
    if0.REQ_RAND_REQU = 3'b000;
    @(negedge CLK);
    n_total++; if (if0.SRC_RAND_REQU !== 1'b0) $display("FAIL single_drop_src: got %b want 0", if0.SRC_RAND_REQU); else n_pass++;
    n_total++; if (if0.REQ_RAND_VALID !== 3'b000) $display("FAIL single_drop_valid: got %b want 000", if0.REQ_RAND_VALID); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if ({ga0, busy0} !== 2'b01) $display("FAIL single_release: got ga/busy %b want 01", {ga0, busy0}); else n_pass++;
    tick();
    if0.SRC_RAND_VALID = 1'b0;
    @(negedge CLK);
    n_total++; if (busy0 !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    int unsigned gap, exp_gap;
    do_reset();
    if0.REQ_RAND_REQU  = 3'b111;
    if0.SRC_RAND_VALID = 1'b1;
    if0.SRC_NEW_RAND   = 32'h2000_0000;
    @(negedge CLK);
    for (int o = 0; o < 3; o++) begin
      base = 32'h2000_0000 + 32'(o * 16);
      gap  = 0;
      while (!ga0 && gap < 8) begin
        n_total++; if (if0.SRC_RAND_REQU !== 1'b0) $display("FAIL b2b_gap_src[%0d]: got %b want 0", o, if0.SRC_RAND_REQU); else n_pass++;
        gap++;
        tick();
        if0.SRC_NEW_RAND = base;
        @(negedge CLK);
      end
      exp_gap = (o == 0) ? 1 : 2;
      n_total++; if (gap !== exp_gap) $display("FAIL b2b_gap[%0d]: got %0d want %0d", o, gap, exp_gap); else n_pass++;
      n_total++; if ({ga0, gi0} !== {1'b1, 2'(o)}) $display("FAIL b2b_owner[%0d]: got ga/idx %b want %b", o, {ga0, gi0}, {1'b1, 2'(o)}); else n_pass++;
      n_total++; if (if0.REQ_RAND_VALID !== (3'b001 << o)) $display("FAIL b2b_valid0[%0d]: got %b want %b", o, if0.REQ_RAND_VALID, 3'b001 << o); else n_pass++;
      n_total++; if (if0.REQ_NEW_RAND !== base) $display("FAIL b2b_data0[%0d]: got %h want %h", o, if0.REQ_NEW_RAND, base); else n_pass++;
      tick();
      if0.SRC_NEW_RAND = base + 32'd1;
      @(negedge CLK);
      n_total++; if (if0.REQ_NEW_RAND !== base + 32'd1) $display("FAIL b2b_data1[%0d]: got %h want %h", o, if0.REQ_NEW_RAND, base + 32'd1); else n_pass++;
      tick();
      if0.REQ_RAND_REQU = if0.REQ_RAND_REQU & ~(3'b001 << o);
      @(negedge CLK);
      n_total++; if ({if0.SRC_RAND_REQU, if0.REQ_RAND_VALID} !== 4'b0000) $display("FAIL b2b_drop[%0d]: got src/valid %b want 0000", o, {if0.SRC_RAND_REQU, if0.REQ_RAND_VALID}); else n_pass++;
      tick();
      @(negedge CLK);
    end
    tick();
    if0.SRC_RAND_VALID = 1'b0;
    @(negedge CLK);
    n_total++; if (busy0 !== 1'b0) $display("FAIL b2b_idle: got busy %b want 0", busy0); else n_pass++;
  endtask

  task automatic test_burst_limit();
    int unsigned src_cnt, rcv_cnt, cur_owner, cur_words, wait_cyc;
    int unsigned own_q[$];
    int unsigned words_q[$];
    int unsigned exp_own[4];
    logic        prev_ga;
    logic [31:0] exp;
    exp_own   = '{0, 2, 0, 2};
    src_cnt   = 0;
    rcv_cnt   = 0;
    cur_owner = 0;
    cur_words = 0;
    prev_ga   = 1'b0;
    do_reset();
    if4.REQ_RAND_REQU  = 3'b101;
    if4.SRC_RAND_VALID = 1'b1;
    if4.SRC_NEW_RAND   = 32'h3000_0000;
    for (int c = 0; c < 42; c++) begin
      @(negedge CLK);
      if (ga4 && !prev_ga) begin
        cur_owner = 32'(gi4);
        cur_words = 0;
      end
      if (|if4.REQ_RAND_VALID) begin
        exp = 32'h3000_0000 + rcv_cnt;
        n_total++; if (if4.REQ_RAND_VALID !== 3'b001 && if4.REQ_RAND_VALID !== 3'b100) $display("FAIL burst_onehot[%0d]: got %b want 001 or 100", c, if4.REQ_RAND_VALID); else n_pass++;
        n_total++; if (if4.REQ_NEW_RAND !== exp) $display("FAIL burst_data[%0d]: got %h want %h", c, if4.REQ_NEW_RAND, exp); else n_pass++;
        rcv_cnt++;
        cur_words++;
      end
      if (if4.SRC_RAND_REQU && if4.SRC_RAND_VALID) src_cnt++;
      if (!ga4 && prev_ga) begin
        own_q.push_back(cur_owner);
        words_q.push_back(cur_words);
      end
      prev_ga = ga4;
      tick();
      if4.SRC_NEW_RAND = 32'h3000_0000 + src_cnt;
    end
    n_total++; if (src_cnt !== rcv_cnt) $display("FAIL burst_no_loss: got delivered %0d want accepted %0d", rcv_cnt, src_cnt); else n_pass++;
    n_total++; if (own_q.size() < 4) $display("FAIL burst_grants: got %0d grants want at least 4", own_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < own_q.size()) begin
        n_total++; if (own_q[i] !== exp_own[i]) $display("FAIL burst_owner[%0d]: got %0d want %0d", i, own_q[i], exp_own[i]); else n_pass++;
        n_total++; if (words_q[i] !== 4) $display("FAIL burst_words[%0d]: got %0d want 4", i, words_q[i]); else n_pass++;
      end
    end
    if4.REQ_RAND_REQU  = 3'b000;
    if4.SRC_RAND_VALID = 1'b0;
    wait_cyc = 0;
    @(negedge CLK);
    while (busy4 && wait_cyc < 10) begin
      tick();
      @(negedge CLK);
      wait_cyc++;
    end
    n_total++; if (busy4 !== 1'b0) $display("FAIL burst_idle: got busy %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_unbounded();
    int unsigned rcv, starts, drops;
    logic        prev_ga;
    logic [31:0] exp;
    rcv     = 0;
    starts  = 0;
    drops   = 0;
    prev_ga = 1'b0;
    tick();
    if4.REQ_RAND_REQU  = 3'b010;
    if4.SRC_RAND_VALID = 1'b1;
    if4.SRC_NEW_RAND   = 32'h4000_0000;
    for (int c = 0; c < 20 && rcv < 10; c++) begin
      @(negedge CLK);
      if (ga4 && !prev_ga) starts++;
      if (prev_ga && !ga4) drops++;
      if (|if4.REQ_RAND_VALID) begin
        exp = 32'h4000_0000 + rcv;
        n_total++; if (if4.REQ_RAND_VALID !== 3'b010) $display("FAIL unb_valid[%0d]: got %b want 010", rcv, if4.REQ_RAND_VALID); else n_pass++;
        n_total++; if (if4.REQ_NEW_RAND !== exp) $display("FAIL unb_data[%0d]: got %h want %h", rcv, if4.REQ_NEW_RAND, exp); else n_pass++;
        rcv++;
      end
      prev_ga = ga4;
      tick();
      if4.SRC_NEW_RAND = 32'h4000_0000 + rcv;
    end
    if4.REQ_RAND_REQU = 3'b000;
    @(negedge CLK);
    n_total++; if (rcv !== 10) $display("FAIL unb_words: got %0d want 10", rcv); else n_pass++;
    n_total++; if (starts !== 1) $display("FAIL unb_grants: got %0d want 1", starts); else n_pass++;
    n_total++; if (drops !== 0) $display("FAIL unb_release: got %0d want 0", drops); else n_pass++;
    n_total++; if ({ga4, gi4, if4.SRC_RAND_REQU} !== 4'b1010) $display("FAIL unb_drop: got ga/idx/src %b want 1010", {ga4, gi4, if4.SRC_RAND_REQU}); else n_pass++;
    tick();
    tick();
    if4.SRC_RAND_VALID = 1'b0;
    @(negedge CLK);
    n_total++; if (busy4 !== 1'b0) $display("FAIL unb_idle: got busy %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_idle_drop();
    tick();
    if0.REQ_RAND_REQU  = 3'b000;
    if0.SRC_RAND_VALID = 1'b1;
    if0.SRC_NEW_RAND   = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_total++; if ({if0.SRC_RAND_REQU, if0.REQ_RAND_VALID} !== 4'b0000) $display("FAIL idle_valid[%0d]: got src/valid %b want 0000", c, {if0.SRC_RAND_REQU, if0.REQ_RAND_VALID}); else n_pass++;
      n_total++; if (if0.REQ_NEW_RAND !== 32'h0) $display("FAIL idle_data[%0d]: got %h want 0", c, if0.REQ_NEW_RAND); else n_pass++;
      tick();
    end
    if0.REQ_RAND_REQU = 3'b001;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    n_total++; if ({if0.REQ_RAND_VALID, if0.REQ_NEW_RAND} !== {3'b001, 32'hDEADBEEF}) $display("FAIL idle_grant_word: got %b/%h want 001/deadbeef", if0.REQ_RAND_VALID, if0.REQ_NEW_RAND); else n_pass++;
    tick();
    if0.REQ_RAND_REQU = 3'b000;
    @(negedge CLK);
    n_total++; if (if0.REQ_NEW_RAND !== 32'h0) $display("FAIL idle_drop_data: got %h want 0", if0.REQ_NEW_RAND); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if ({ga0, busy0} !== 2'b01) $display("FAIL rel_state: got ga/busy %b want 01", {ga0, busy0}); else n_pass++;
    n_total++; if ({if0.SRC_RAND_REQU, if0.REQ_RAND_VALID} !== 4'b0000) $display("FAIL rel_valid: got src/valid %b want 0000", {if0.SRC_RAND_REQU, if0.REQ_RAND_VALID}); else n_pass++;
    n_total++; if (if0.REQ_NEW_RAND !== 32'h0) $display("FAIL rel_data: got %h want 0", if0.REQ_NEW_RAND); else n_pass++;
    tick();
    if0.SRC_RAND_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] exp;
    // Short grant to req0 so the pointer sits at 1 before the burst.
    do_reset();
    if0.REQ_RAND_REQU  = 3'b001;
    if0.SRC_RAND_VALID = 1'b0;
    tick();
    tick();
    if0.REQ_RAND_REQU = 3'b000;
    tick();
    tick();
    if0.REQ_RAND_REQU  = 3'b110;
    if0.SRC_RAND_VALID = 1'b1;
    if0.SRC_NEW_RAND   = 32'h5000_0000;
    @(negedge CLK);
    for (int w = 0; w < 3; w++) begin
      tick();
      exp = 32'h5000_0000 + 32'(w);
      if0.SRC_NEW_RAND = exp;
      @(negedge CLK);
      n_total++; if ({if0.REQ_RAND_VALID, if0.REQ_NEW_RAND} !== {3'b010, exp}) $display("FAIL rst_burst[%0d]: got %b/%h want 010/%h", w, if0.REQ_RAND_VALID, if0.REQ_NEW_RAND, exp); else n_pass++;
    end
    tick();
    if0.SRC_NEW_RAND = 32'h5000_0003;
    RESET = 1'b1;
    #1;
    n_total++; if ({if0.SRC_RAND_REQU, if0.REQ_RAND_VALID} !== 4'b0000) $display("FAIL rst_mid_valid: got src/valid %b want 0000", {if0.SRC_RAND_REQU, if0.REQ_RAND_VALID}); else n_pass++;
    n_total++; if (if0.REQ_NEW_RAND !== 32'h0) $display("FAIL rst_mid_data: got %h want 0", if0.REQ_NEW_RAND); else n_pass++;
    n_total++; if ({ga0, busy0, gi0} !== 4'b0000) $display("FAIL rst_mid_status: got %b want 0000", {ga0, busy0, gi0}); else n_pass++;
    if0.REQ_RAND_REQU = 3'b100;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    n_total++; if (ga0 !== 1'b0) $display("FAIL rst_rel_c1: got ga %b want 0", ga0); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if ({ga0, gi0, if0.REQ_RAND_VALID} !== {1'b1, 2'd2, 3'b100}) $display("FAIL rst_rel_c2: got %b want 110100", {ga0, gi0, if0.REQ_RAND_VALID}); else n_pass++;
    // Move the pointer to 1 again, then reset while idle: the pointer must return to 0.
    tick();
    if0.REQ_RAND_REQU = 3'b000;
    tick();
    tick();
    if0.REQ_RAND_REQU = 3'b001;
    tick();
    tick();
    if0.REQ_RAND_REQU = 3'b000;
    tick();
    tick();
    RESET = 1'b1;
    if0.REQ_RAND_REQU = 3'b011;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    n_total++; if (ga0 !== 1'b0) $display("FAIL rst_rr_c1: got ga %b want 0", ga0); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if ({ga0, gi0} !== 3'b100) $display("FAIL rst_rr_ptr: got ga/idx %b want 100", {ga0, gi0}); else n_pass++;
    tick();
    if0.REQ_RAND_REQU  = 3'b000;
    if0.SRC_RAND_VALID = 1'b0;
    tick();
    tick();
    tick();
    @(negedge CLK);
    n_total++; if (busy0 !== 1'b0) $display("FAIL rst_final_idle: got busy %b want 0", busy0); else n_pass++;
  endtask

  initial begin
    quiet_all();
    test_reset();
    test_single();
    test_back_to_back();
    test_burst_limit();
    test_unbounded();
    test_idle_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bike_rand_arbiter.md
Name: bike_rand_arbiter

Overview:
- Shares one 32-bit randomness source (TRNG/PRNG word stream) between NUM_REQ uniform samplers, e.g. sigma, m and private-key seed samplers.
- Each sampler keeps its own REQU/VALID/NEW_RAND interface; the arbiter passes a granted requester's handshake through to the source.
- Round-robin grant with an optional burst limit so that a long sampler cannot starve the others.
- Sits between the randomness generator and the sampler bank in the BIKE top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 32, width of a randomness word.
- MAX_BURST, 0, maximum number of words per grant while others are waiting; 0 means unlimited.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_RAND_REQU  in  NUM_REQ  per-requester randomness request; held high while the requester wants words.
- REQ_RAND_VALID  out  NUM_REQ  per-requester word strobe, one-hot or zero.
- REQ_NEW_RAND  out  DATA_WIDTH  shared word bus to requesters.
- SRC_RAND_REQU  out  1  request to the randomness source.
- SRC_RAND_VALID  in  1  source word strobe.
- SRC_NEW_RAND  in  DATA_WIDTH  source word.
- GRANT_IDX  out  clog2(NUM_REQ) (min 1)  index of the current owner; valid only while GRANT_ACTIVE is high.
- GRANT_ACTIVE  out  1  high in S_GRANT.
- BUSY  out  1  high when the state is not S_IDLE.

Behaviour:
- Reset (async, RESET=1): state=S_IDLE, RR_PTR=0, GRANT_IDX=0, BURST_CNT=0. All outputs 0. A reset mid-burst aborts immediately; a word presented in that cycle is dropped.
- States:
  - S_IDLE: SRC_RAND_REQU=0. If REQ_RAND_REQU is nonzero, select the first set bit scanning RR_PTR, RR_PTR+1, ... (mod NUM_REQ). Register GRANT_IDX, clear BURST_CNT, go to S_GRANT. Otherwise stay.
  - S_GRANT, with g=GRANT_IDX:
    - SRC_RAND_REQU = REQ_RAND_REQU[g] & ~LIMIT_HIT.
    - DELIVER = SRC_RAND_VALID & SRC_RAND_REQU.
    - REQ_RAND_VALID[g] = DELIVER; all other bits 0.
    - REQ_NEW_RAND = SRC_NEW_RAND when DELIVER, else 0.
    - BURST_CNT increments on DELIVER and saturates at MAX_BURST.
    - LIMIT_HIT = (MAX_BURST!=0) & (BURST_CNT==MAX_BURST) & (any REQ_RAND_REQU bit other than g set).
    - Exit to S_RELEASE when REQ_RAND_REQU[g]==0 or LIMIT_HIT. On exit, RR_PTR <= (g+1) mod NUM_REQ.
  - S_RELEASE: one-cycle bubble. SRC_RAND_REQU=0 and all REQ_RAND_VALID=0. Any SRC_RAND_VALID is discarded. Next state is S_IDLE.
- Latency: REQU rising in cycle t (arbiter idle) → GRANT_ACTIVE and SRC_RAND_REQU high in t+1. The earliest delivered word is in t+1.
- Handover: minimum 2 idle cycles between two owners (S_RELEASE, then S_IDLE arbitration).
- Source words arriving while SRC_RAND_REQU=0 are silently dropped and never forwarded.
- Owner drops REQU mid-burst (sampler done): a same-cycle SRC_RAND_VALID is not delivered.
- Burst limit: a requester cut off by LIMIT_HIT that keeps REQU high re-competes; it is lowest priority because RR_PTR has moved past it.
- Burst limit with no other requester pending: LIMIT_HIT stays 0 and the grant continues unbounded.
- Simultaneous new requests during S_GRANT do not preempt the owner; they are considered only in S_IDLE.
- GRANT_IDX holds its last value outside S_GRANT; consumers must qualify it with GRANT_ACTIVE.
- Invariant: at most one REQ_RAND_VALID bit is high in any cycle.

Test Plan:
- NUM_REQ=3, MAX_BURST=0. Req1 alone asserts REQU for 8 source words, each with DOUT=0x1000_000k → REQ_RAND_VALID=3'b010 for exactly 8 cycles carrying those values. SRC_RAND_REQU falls in the cycle req1 drops REQU.
- Reqs 0, 1, 2 all assert REQU in the same cycle with RR_PTR=0 → grant order is 0, 1, 2 as each finishes. Each handover shows exactly 2 cycles with SRC_RAND_REQU=0.
- MAX_BURST=4, req0 and req2 held high continuously, source valid every cycle → owners alternate 0, 2, 0, 2 with exactly 4 words per grant. No word is lost and none is duplicated.
- MAX_BURST=4, req1 alone held high for 10 words → a single grant delivers all 10 words with no release.
- Source asserts SRC_RAND_VALID in S_IDLE and S_RELEASE with data 0xDEADBEEF → all REQ_RAND_VALID bits stay 0 and REQ_NEW_RAND stays 0.
- RESET pulsed mid-burst after 3 words → all outputs are 0 in the same cycle and RR_PTR=0. After release, a pending req2 is granted in the second cycle.
